// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART ring-buffer port arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_WAIT  = 2'd3
    } arb_state_t;

    localparam int          ARB_NUM_CLIENTS = 2;
    localparam int          ARB_DATA_W      = 8;
    localparam logic [15:0] ARB_STAT_MAX    = 16'hFFFF;

    // Client index width; a single client still needs one bit to carry an index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward starting one past last_grant.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = ARB_NUM_CLIENTS,
    localparam int IDX_W      = idx_w(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic                   grant_valid,
    output logic [IDX_W-1:0]       grant_idx
);

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        int w_idx;
        w_idx       = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_CLIENTS; i >= 1; i--) begin
            w_idx = (int'(last_grant) + i) % NUM_CLIENTS;
            if (req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_buffer_arbiter.sv
// Shares one ring-buffer port among NUM_CLIENTS requesters; all outputs registered.
// Optional UART_ARB_STATS_EN adds saturating write / empty-read counters.
//
// state       | meaning
// ST_IDLE     | waiting for any req_valid; grants round-robin
// ST_WRITE    | write strobe was issued last cycle; return to idle
// ST_RD_ISSUE | read strobe was issued last cycle; wait for buffer
// ST_RD_WAIT  | sample buffer ack/data once and respond to client
module uart_buffer_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = ARB_NUM_CLIENTS,
    parameter int DATA_W      = ARB_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    input  logic [NUM_CLIENTS-1:0]        req_write,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    output logic [NUM_CLIENTS-1:0]        rsp_valid,
    output logic                          rsp_empty,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          buf_write_en,
    output logic [DATA_W-1:0]             buf_write_data,
    output logic                          buf_read_en,
    input  logic                          buf_read_ack,
    input  logic [DATA_W-1:0]             buf_read_data,
    output logic                          busy
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]                   stat_writes,
    output logic [15:0]                   stat_empty_reads
`endif
);

    localparam int               IDX_W    = idx_w(NUM_CLIENTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

    arb_state_t              r_state, w_state;
    logic [IDX_W-1:0]        r_last_grant, w_last_grant;
    logic [IDX_W-1:0]        r_cur_client, w_cur_client;
    logic [NUM_CLIENTS-1:0]  r_req_ready, w_req_ready;
    logic [NUM_CLIENTS-1:0]  r_rsp_valid, w_rsp_valid;
    logic                    r_rsp_empty, w_rsp_empty;
    logic [DATA_W-1:0]       r_rsp_data, w_rsp_data;
    logic                    r_buf_write_en, w_buf_write_en;
    logic [DATA_W-1:0]       r_buf_write_data, w_buf_write_data;
    logic                    r_buf_read_en, w_buf_read_en;
    logic                    r_busy, w_busy;
    logic                    w_stat_write_inc;
    logic                    w_stat_empty_inc;
    logic                    w_grant_valid;
    logic [IDX_W-1:0]        w_grant_idx;

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_state          = r_state;
        w_last_grant     = r_last_grant;
        w_cur_client     = r_cur_client;
        w_req_ready      = '0;
        w_rsp_valid      = '0;
        w_rsp_empty      = r_rsp_empty;
        w_rsp_data       = r_rsp_data;
        w_buf_write_en   = 1'b0;
        w_buf_write_data = r_buf_write_data;
        w_buf_read_en    = 1'b0;
        w_stat_write_inc = 1'b0;
        w_stat_empty_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_last_grant             = w_grant_idx;
                    w_cur_client             = w_grant_idx;
                    if (req_write[w_grant_idx]) begin
                        w_buf_write_data = req_wdata[w_grant_idx*DATA_W +: DATA_W];
                        w_buf_write_en   = 1'b1;
                        w_stat_write_inc = 1'b1;
                        w_state          = ST_WRITE;
                    end else begin
                        w_buf_read_en = 1'b1;
                        w_state       = ST_RD_ISSUE;
                    end
                end
            end
            ST_WRITE:    w_state = ST_IDLE;
            ST_RD_ISSUE: w_state = ST_RD_WAIT;
            ST_RD_WAIT: begin
                // The buffer holds its ack level between reads, so only this cycle's ack is trusted.
                w_rsp_valid[r_cur_client] = 1'b1;
                w_rsp_empty               = ~buf_read_ack;
                w_rsp_data                = buf_read_data;
                w_stat_empty_inc          = ~buf_read_ack;
                w_state                   = ST_IDLE;
            end
            default:     w_state = ST_IDLE;
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_last_grant     <= LAST_IDX;
            r_cur_client     <= '0;
            r_req_ready      <= '0;
            r_rsp_valid      <= '0;
            r_rsp_empty      <= 1'b0;
            r_rsp_data       <= '0;
            r_buf_write_en   <= 1'b0;
            r_buf_write_data <= '0;
            r_buf_read_en    <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state;
            r_last_grant     <= w_last_grant;
            r_cur_client     <= w_cur_client;
            r_req_ready      <= w_req_ready;
            r_rsp_valid      <= w_rsp_valid;
            r_rsp_empty      <= w_rsp_empty;
            r_rsp_data       <= w_rsp_data;
            r_buf_write_en   <= w_buf_write_en;
            r_buf_write_data <= w_buf_write_data;
            r_buf_read_en    <= w_buf_read_en;
            r_busy           <= w_busy;
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_empty      = r_rsp_empty;
    assign rsp_data       = r_rsp_data;
    assign buf_write_en   = r_buf_write_en;
    assign buf_write_data = r_buf_write_data;
    assign buf_read_en    = r_buf_read_en;
    assign busy           = r_busy;

`ifdef UART_ARB_STATS_EN
    logic [15:0] r_stat_writes;
    logic [15:0] r_stat_empty_reads;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_writes      <= '0;
            r_stat_empty_reads <= '0;
        end else begin
            if (w_stat_write_inc && (r_stat_writes != ARB_STAT_MAX))
                r_stat_writes <= r_stat_writes + 16'd1;
            if (w_stat_empty_inc && (r_stat_empty_reads != ARB_STAT_MAX))
                r_stat_empty_reads <= r_stat_empty_reads + 16'd1;
        end
    end

    assign stat_writes      = r_stat_writes;
    assign stat_empty_reads = r_stat_empty_reads;
`endif

endmodule

// File: tb/tb_uart_buffer_arbiter.sv
// Directed bench for uart_buffer_arbiter with a registered ring-buffer read model.
module tb_uart_buffer_arbiter;

    localparam int NC = 2;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NC-1:0]    req_valid;
    logic [NC-1:0]    req_write;
    logic [NC*DW-1:0] req_wdata;
    logic [NC-1:0]    req_ready;
    logic [NC-1:0]    rsp_valid;
    logic             rsp_empty;
    logic [DW-1:0]    rsp_data;
    logic             buf_write_en;
    logic [DW-1:0]    buf_write_data;
    logic             buf_read_en;
    logic             buf_read_ack = 1'b0;
    logic [DW-1:0]    buf_read_data = '0;
    logic             busy;
`ifdef UART_ARB_STATS_EN
    logic [15:0]      stat_writes;
    logic [15:0]      stat_empty_reads;
`endif

    logic             m_empty;
    logic [DW-1:0]    m_byte;

    int n_tests = 0;
    int n_fail  = 0;
    int overlap = 0;
    int rd_pulses = 0;
    int rsp_count = 0;
    logic [NC-1:0] grants[$];

    uart_buffer_arbiter #(.NUM_CLIENTS(NC), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_empty      (rsp_empty),
        .rsp_data       (rsp_data),
        .buf_write_en   (buf_write_en),
        .buf_write_data (buf_write_data),
        .buf_read_en    (buf_read_en),
        .buf_read_ack   (buf_read_ack),
        .buf_read_data  (buf_read_data),
        .busy           (busy)
`ifdef UART_ARB_STATS_EN
        ,
        .stat_writes      (stat_writes),
        .stat_empty_reads (stat_empty_reads)
`endif
    );

    always #5 clk = ~clk;

    // Registered buffer: ack/data update one cycle after a read strobe and hold otherwise.
    always @(posedge clk) begin
        if (buf_read_en) begin
            buf_read_ack  <= ~m_empty;
            buf_read_data <= m_byte;
        end
    end

    always @(negedge clk) begin
        if (buf_write_en && buf_read_en) overlap++;
        if (buf_read_en) rd_pulses++;
        if (rsp_valid != '0) rsp_count++;
        if (req_ready != '0) grants.push_back(req_ready);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        req_valid = '0;
        req_write = '0;
        req_wdata = '0;
        m_empty   = 1'b1;
        m_byte    = '0;

        repeat (2) @(negedge clk);
        chk("rst_outs", {req_ready, rsp_valid, rsp_empty, buf_write_en, buf_read_en, busy}, 32'h0);
        chk("rst_data", {rsp_data, buf_write_data}, 32'h0);

        // client 0 writes A5
        reset     = 1'b0;
        req_valid = 2'b01;
        req_write = 2'b01;
        req_wdata = {8'h00, 8'hA5};
        @(negedge clk);
        chk("wr_ready", req_ready, 2'b01);
        chk("wr_en", buf_write_en, 1'b1);
        chk("wr_data", buf_write_data, 8'hA5);
        chk("wr_busy", busy, 1'b1);
        req_valid = '0;
        @(negedge clk);
        chk("wr_en_off", {req_ready, buf_write_en, buf_read_en}, 32'h0);
        chk("wr_busy_off", busy, 1'b0);
`ifdef UART_ARB_STATS_EN
        chk("stat_wr1", stat_writes, 16'd1);
`endif

        // client 1 reads 3C
        m_empty   = 1'b0;
        m_byte    = 8'h3C;
        rd_pulses = 0;
        req_valid = 2'b10;
        req_write = 2'b00;
        @(negedge clk);
        chk("rd_ready", req_ready, 2'b10);
        chk("rd_en", {buf_read_en, buf_write_en}, 2'b10);
        req_valid = '0;
        @(negedge clk);
        chk("rd_wait", {rsp_valid, buf_read_en, busy}, 4'b0001);
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 2'b10);
        chk("rd_rsp_empty", rsp_empty, 1'b0);
        chk("rd_rsp_data", rsp_data, 8'h3C);
        chk("rd_busy_off", busy, 1'b0);
        chk("rd_pulses", rd_pulses, 1);

        // client 0 reads an empty buffer while the model still holds ack=1
        m_empty   = 1'b1;
        m_byte    = 8'hEE;
        req_valid = 2'b01;
        @(negedge clk);
        chk("erd_ready", req_ready, 2'b01);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("erd_rsp_valid", rsp_valid, 2'b01);
        chk("erd_rsp_empty", rsp_empty, 1'b1);
`ifdef UART_ARB_STATS_EN
        chk("stat_empty1", stat_empty_reads, 16'd1);
`endif

        // single requester held: granted on every idle visit
        grants.delete();
        req_valid = 2'b10;
        req_write = 2'b10;
        req_wdata = {8'h77, 8'h00};
        repeat (8) @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("single_cnt", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) chk("single_grant", grants[i], 2'b10);
`ifdef UART_ARB_STATS_EN
        chk("stat_wr5", stat_writes, 16'd5);
`endif

        // both clients continuously after reset: 0 writes, 1 reads
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        m_empty   = 1'b0;
        m_byte    = 8'h5A;
        overlap   = 0;
        grants.delete();
        req_valid = 2'b11;
        req_write = 2'b01;
        req_wdata = {8'h00, 8'h11};
        repeat (12) @(negedge clk);
        req_valid = '0;
        chk("alt_cnt_ge4", grants.size() >= 4, 1'b1);
        if (grants.size() >= 4) begin
            chk("alt_g0", grants[0], 2'b01);
            chk("alt_g1", grants[1], 2'b10);
            chk("alt_g2", grants[2], 2'b01);
            chk("alt_g3", grants[3], 2'b10);
        end
        chk("no_overlap", overlap, 0);
        repeat (3) @(negedge clk);

        // reset while in RD_ISSUE aborts the read
        req_valid = 2'b01;
        req_write = 2'b00;
        @(negedge clk);
        chk("abort_issue", {req_ready, buf_read_en, busy}, 4'b0111);
        reset     = 1'b1;
        rsp_count = 0;
        req_valid = 2'b11;
        req_write = 2'b11;
        req_wdata = {8'h22, 8'h33};
        @(negedge clk);
        chk("abort_outs", {req_ready, rsp_valid, rsp_empty, buf_write_en, buf_read_en, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_first", req_ready, 2'b01);
        chk("abort_wdata", buf_write_data, 8'h33);
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", rsp_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
